// File: rtl/ram_rr_arbiter.sv
// Two-requester round-robin arbiter feeding a single-port RAM with registered commands.
// Read results are routed back to the issuing requester through a 2-deep owner pipeline.
module ram_rr_arbiter #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req0,
    input  logic                       we0,
    input  logic [$clog2(DEPTH)-1:0]   addr0,
    input  logic [WIDTH-1:0]           wdata0,
    output logic                       gnt0,
    output logic                       rvalid0,
    output logic [WIDTH-1:0]           rdata0,
    input  logic                       req1,
    input  logic                       we1,
    input  logic [$clog2(DEPTH)-1:0]   addr1,
    input  logic [WIDTH-1:0]           wdata1,
    output logic                       gnt1,
    output logic                       rvalid1,
    output logic [WIDTH-1:0]           rdata1,
    output logic                       ram_w_en,
    output logic [$clog2(DEPTH)-1:0]   ram_addr,
    output logic [WIDTH-1:0]           ram_data_in,
    input  logic [WIDTH-1:0]           ram_data_out
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        OWN0 = 1'b0,
        OWN1 = 1'b1
    } owner_e;

    owner_e          r_last;
    owner_e          r_s1_own;
    owner_e          r_s2_own;
    logic            r_s1_vld;
    logic            r_s2_vld;
    logic            r_ram_w_en;
    logic [AW-1:0]   r_ram_addr;
    logic [WIDTH-1:0] r_ram_data_in;
    logic [WIDTH-1:0] r_rdata0;
    logic [WIDTH-1:0] r_rdata1;

    logic            w_gnt0;
    logic            w_gnt1;
    logic            w_any;
    logic            w_we;
    logic [AW-1:0]   w_addr;
    logic [WIDTH-1:0] w_wdata;
    logic            w_rvalid0;
    logic            w_rvalid1;

    // Contention goes to the requester that did not win last; grants are masked during reset.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!rst) begin
            if (req0 && req1) begin
                if (r_last == OWN0) w_gnt1 = 1'b1;
                else                w_gnt0 = 1'b1;
            end else begin
                w_gnt0 = req0;
                w_gnt1 = req1;
            end
        end
    end

    always_comb begin
        w_any   = w_gnt0 | w_gnt1;
        w_we    = w_gnt1 ? we1    : we0;
        w_addr  = w_gnt1 ? addr1  : addr0;
        w_wdata = w_gnt1 ? wdata1 : wdata0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last        <= OWN0;
            r_ram_w_en    <= 1'b0;
            r_ram_addr    <= '0;
            r_ram_data_in <= '0;
            r_s1_vld      <= 1'b0;
            r_s1_own      <= OWN0;
            r_s2_vld      <= 1'b0;
            r_s2_own      <= OWN0;
            r_rdata0      <= '0;
            r_rdata1      <= '0;
        end else begin
            if (w_any) begin
                r_ram_w_en    <= w_we;
                r_ram_addr    <= w_addr;
                r_ram_data_in <= w_wdata;
                r_last        <= w_gnt1 ? OWN1 : OWN0;
            end else begin
                r_ram_w_en    <= 1'b0;
            end
            r_s1_vld <= w_any && !w_we;
            r_s1_own <= w_gnt1 ? OWN1 : OWN0;
            r_s2_vld <= r_s1_vld;
            r_s2_own <= r_s1_own;
            if (w_rvalid0) r_rdata0 <= ram_data_out;
            if (w_rvalid1) r_rdata1 <= ram_data_out;
        end
    end

    // Read data passes straight through while valid and is held afterwards.
    always_comb begin
        w_rvalid0 = r_s2_vld && (r_s2_own == OWN0);
        w_rvalid1 = r_s2_vld && (r_s2_own == OWN1);
    end

    assign gnt0        = w_gnt0;
    assign gnt1        = w_gnt1;
    assign rvalid0     = w_rvalid0;
    assign rvalid1     = w_rvalid1;
    assign rdata0      = w_rvalid0 ? ram_data_out : r_rdata0;
    assign rdata1      = w_rvalid1 ? ram_data_out : r_rdata1;
    assign ram_w_en    = r_ram_w_en;
    assign ram_addr    = r_ram_addr;
    assign ram_data_in = r_ram_data_in;

endmodule

// File: doc/ram_rr_arbiter.md
Name: ram_rr_arbiter

Overview:
Two-requester round-robin arbiter and sequencer in front of the single-port RAM (w_en/addr/data_in/data_out). It accepts one read or write per cycle from either requester and drives a registered command onto the RAM port. It tracks read ownership so that each read result returns only to the requester that issued it. It sits between the requester agents/DUT masters and the RAM instance.

Parameters:
DEPTH, 8, RAM word count; address width is $clog2(DEPTH)
WIDTH, 8, data word width in bits

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  asynchronous, active-high reset
req0  input  1  requester 0 command valid
we0  input  1  requester 0: 1=write, 0=read
addr0  input  $clog2(DEPTH)  requester 0 address
wdata0  input  WIDTH  requester 0 write data
gnt0  output  1  requester 0 command accepted this cycle (combinational)
rvalid0  output  1  requester 0 read data valid
rdata0  output  WIDTH  requester 0 read data
req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1  same as above, for requester 1
ram_w_en  output  1  registered RAM write enable
ram_addr  output  $clog2(DEPTH)  registered RAM address
ram_data_in  output  WIDTH  registered RAM write data
ram_data_out  input  WIDTH  RAM read data, valid the cycle after RAM samples addr

Behaviour:
- Reset (async assert, sync deassert by the environment) clears: ram_w_en=0, ram_addr=0, ram_data_in=0, rvalid0/1=0, rdata0/1=0, in-flight pipeline cleared, priority pointer = requester 0.
- Handshake: the requester holds req/we/addr/wdata stable until it sees gnt high. The command is consumed on the posedge where gnt=1. gnt is never asserted without req, and gnt0 and gnt1 are never both high.
- Arbitration (cycle N, combinational):
  - Only one req high: that requester is granted.
  - Both high: the requester opposite to the priority pointer's last winner is granted. The pointer stores the last granted id and updates only on a grant.
  - Neither high: no grant, pointer holds.
- Command stage: on the posedge ending cycle N, the granted command is registered onto ram_* (visible in cycle N+1).
  - With no grant, ram_w_en=0; ram_addr and ram_data_in hold their previous values (idle read of a stale address, whose result is discarded).
- Read return:
  - The RAM samples in cycle N+1 and ram_data_out is valid in cycle N+2.
  - A 2-deep owner/valid shift pipeline tags each granted read.
  - In cycle N+2, the owner's rvalid=1 and rdata registered-to-output = ram_data_out (rdata is passed combinationally from ram_data_out while rvalid is high; otherwise it holds its last value).
  - Total read latency is 2 cycles from the gnt cycle.
  - Writes produce no rvalid.
- Throughput: one command per cycle sustained. Back-to-back reads from both requesters interleave with no bubbles.
- Ordering: commands reach the RAM in grant order. A write granted in cycle N followed by a read of the same address granted in cycle N+1 returns the new data.
- Starvation bound: with both requesters continuously requesting, each is granted every other cycle; maximum wait is 1 cycle.
- Reset mid-operation: in-flight reads are dropped, with no rvalid after reset deassert for commands granted before reset. A write registered but not yet sampled by the RAM is lost.
- Address width is $clog2(DEPTH). No range checking is done: DEPTH is a power of two, so all addresses are legal.

Test Plan:
- Reset: assert rst mid-stream with reads pending -> all outputs 0 immediately, no rvalid in the 3 cycles after deassert, first contended grant goes to requester 1 (pointer=0 means last winner 0).
- Single requester write/read: req0 we0=1 addr0=3 wdata0=8'hA5, then read addr0=3 -> gnt0 in each request cycle, ram_w_en=1 addr=3 data_in=A5 one cycle later, rvalid0=1 rdata0=A5 two cycles after the read gnt, rvalid1 stays 0.
- Contention: req0 and req1 both held high for 6 cycles, both reads -> grants alternate 1,0,1,0,1,0, and each rvalid returns that requester's data at +2 cycles.
- Write-then-read hazard: gnt0 write addr=5 data=3C in cycle N, gnt1 read addr=5 in cycle N+1 -> rvalid1 in cycle N+3 with rdata1=3C.
- Idle gaps: a single req1 pulse surrounded by idle cycles -> exactly one gnt1 and one ram command, ram_w_en=0 on idle cycles, and the pointer does not change during idle.
- Random mixed traffic against a reference memory model (10k cycles) -> every read matches the model, gnt0&gnt1 is never true, and no requester waits more than 1 cycle.
